vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- VGA timing generator; the consumer end of the clock-divider output.
- Runs on the fast system clock and advances one pixel per pix_en tick from the divider chain.
- Produces hsync/vsync, the active-video flag, pixel coordinates, and line/frame strobes for the pixel-colour logic.
- Default timing is 640x480@60 (25 MHz pixel rate, from 100 MHz with pix_en every 4th clk).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync (0 = active-low)
- CW, 10, counter width; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-advance tick, one clk wide, from clock divider
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- video_on  out  1  high while (x < H_ACTIVE) and (y < V_ACTIVE)
- x  out  CW  current horizontal count, 0..H_TOTAL-1
- y  out  CW  current vertical count, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse when x wraps to 0
- frame_start  out  1  one-clk pulse when x and y both wrap to 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Reset:
  - Applies only on a rising clk edge with rst=1; synchronous, active-high.
  - Overrides pix_en.
  - Reset state: x=0, y=0, video_on=1, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0.
- Counting:
  - All state changes only on clk edges where pix_en=1; with pix_en=0 every output holds, and strobes drop to 0 after one clk.
  - On pix_en, x increments. When x = H_TOTAL-1, x becomes 0 and y advances.
  - y increments, or wraps to 0 from V_TOTAL-1.
  - No other y change.
- Horizontal state machine (derived from x; encodes the phase):
  - ACTIVE: x in 0..H_ACTIVE-1
  - FRONT: next H_FP pixels
  - SYNC: next H_SYNC pixels
  - BACK: remaining H_BP pixels
  - Transitions are strictly ACTIVE->FRONT->SYNC->BACK->ACTIVE at the boundary counts.
  - The vertical phase follows the same scheme over y.
- Registered outputs:
  - hsync, vsync and video_on are registered from the next-state counts, so they are cycle-aligned with x/y. No combinational path from pix_en to any output.
  - hsync = HS_POL exactly for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751).
  - vsync = VS_POL exactly for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491). It changes in the same clk as y.
- Strobes:
  - line_start asserts in the clk where x is loaded with 0 by a wrap.
  - frame_start asserts on a simultaneous x and y wrap; line_start is also high in that cycle.
  - Neither strobe asserts on reset release.
- Boundary conditions:
  - pix_en held high continuously: the block still counts correctly, one pixel per clk.
  - rst asserted mid-line: returns to the reset state on that edge, discarding the partial frame.
  - rst and pix_en asserted together: rst wins.

Decomposition:
- Shared package vga_timing_pkg holds:
  - default timing constants (H_*/V_* for 640x480@60)
  - localparam H_TOTAL/V_TOTAL computation
  - 2-bit phase encoding typedef (ACTIVE/FRONT/SYNC/BACK)
- One natural sub-module, vga_axis_counter:
  - wrap counter with enable, synchronous reset, terminal-count output and phase decode
  - instantiated twice: horizontal counter enabled by pix_en; vertical counter enabled by pix_en AND horizontal terminal count

Test Plan:
- Reset: rst=1 for 3 clks with pix_en toggling -> x=0, y=0, hsync=1, vsync=1, video_on=1, no strobes. Release, then one pix_en -> x=1.
- Line timing: pix_en every 4th clk for 800 ticks -> video_on falls at x=640; hsync low for x=656..751 (96 ticks); line_start pulses once at the x=799->0 wrap with y=1.
- Frame timing: run 420000 ticks -> vsync low exactly for y=490..491; video_on low for all y>=480; frame_start one clk pulse at (799,524)->(0,0); y never exceeds 524.
- Hold: pix_en=0 for 50 clks at x=655 -> all outputs frozen; next tick gives x=656 with hsync=0 in the same cycle.
- Mid-frame reset: assert rst at x=300, y=200 with pix_en=1 -> next clk x=0, y=0, vsync/hsync inactive, frame_start=0.
- Polarity/param: HS_POL=1, VS_POL=1, H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 -> hsync high exactly x=10..12; line period 16 ticks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and phase encoding for the sync generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CW_DEF = 10;

    // Phase of one axis within its line or frame.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // Map a count to its phase; the back porch is whatever remains after sync.
    function automatic phase_e axis_phase(input int c, input int act, input int fp, input int syn);
        if (c < act) begin
            return PH_ACTIVE;
        end else if (c < act + fp) begin
            return PH_FRONT;
        end else if (c < act + fp + syn) begin
            return PH_SYNC;
        end else begin
            return PH_BACK;
        end
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter with enable, terminal count and phase decode.
// The phase of the *next* count is exported so the parent can register sync
// and blanking outputs in the same edge that loads the count.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   PH_ACTIVE | count in 0 .. ACTIVE-1 (visible region)
//   PH_FRONT  | next FP counts after the visible region
//   PH_SYNC   | next SYNC counts, sync pulse asserted
//   PH_BACK   | remaining BP counts before wrapping to 0
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc,
    output phase_e        phase_nxt
);

    localparam int            TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

    logic [CW-1:0] cnt_nxt;

    assign tc = (cnt == LAST);

    // Next count: hold unless enabled, wrap from the last count to zero.
    always_comb begin
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = tc ? '0 : cnt + CW'(1);
        end
    end

    // Phase the axis will be in after this edge.
    always_comb begin
        phase_nxt = axis_phase(int'(cnt_nxt), ACTIVE, FP, SYNC);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator. Advances one pixel per pix_en tick and produces
// registered sync, blanking, coordinates and line/frame strobes.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_tc;
    logic          v_tc;
    logic          v_en;
    phase_e        h_ph_nxt;
    phase_e        v_ph_nxt;

    // The vertical axis only moves on the tick that wraps the horizontal one.
    assign v_en = pix_en & h_tc;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .en        (pix_en),
        .cnt       (h_cnt),
        .tc        (h_tc),
        .phase_nxt (h_ph_nxt)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .en        (v_en),
        .cnt       (v_cnt),
        .tc        (v_tc),
        .phase_nxt (v_ph_nxt)
    );

    assign x = h_cnt;
    assign y = v_cnt;

    // Sync/blank outputs registered from next-state phases so they line up
    // with x/y; strobes mark the edge on which a wrap loads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            video_on    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (h_ph_nxt == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync       <= (v_ph_nxt == PH_SYNC) ? VS_POL : ~VS_POL;
            video_on    <= (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);
            line_start  <= pix_en & h_tc;
            frame_start <= pix_en & h_tc & v_tc;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
module tb_vga_sync_gen;

    // Default-timing instance (A) and a tiny, positive-polarity instance (B).
    localparam int A_HT = 800;
    localparam int A_VT = 525;
    localparam int B_HT = 16;
    localparam int B_VT = 12;

    logic       clk;
    logic       rst;
    logic       pix_en;

    logic       a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start;
    logic [9:0] a_x, a_y;
    logic       b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start;
    logic [4:0] b_x, b_y;

    int vecs;
    int errs;

    // Reference model: linear pixel position within the frame plus strobes.
    int   ma_pos, mb_pos;
    logic ma_ls, ma_fs, mb_ls, mb_fs;

    vga_sync_gen u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .video_on    (a_video_on),
        .x           (a_x),
        .y           (a_y),
        .line_start  (a_line_start),
        .frame_start (a_frame_start)
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .HS_POL   (1'b1), .VS_POL (1'b1), .CW (5)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .video_on    (b_video_on),
        .x           (b_x),
        .y           (b_y),
        .line_start  (b_line_start),
        .frame_start (b_frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [24:0] obs_a();
        return {a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start, a_x, a_y};
    endfunction

    function automatic logic [24:0] obs_b();
        return {b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start, 10'(b_x), 10'(b_y)};
    endfunction

    function automatic logic [24:0] exp_a();
        int   xx, yy;
        logic hs, vs, von;
        xx  = ma_pos % A_HT;
        yy  = ma_pos / A_HT;
        hs  = (xx >= 656 && xx <= 751) ? 1'b0 : 1'b1;
        vs  = (yy >= 490 && yy <= 491) ? 1'b0 : 1'b1;
        von = (xx < 640) && (yy < 480);
        return {hs, vs, von, ma_ls, ma_fs, 10'(xx), 10'(yy)};
    endfunction

    function automatic logic [24:0] exp_b();
        int   xx, yy;
        logic hs, vs, von;
        xx  = mb_pos % B_HT;
        yy  = mb_pos / B_HT;
        hs  = (xx >= 10 && xx <= 12) ? 1'b1 : 1'b0;
        vs  = (yy >= 8 && yy <= 9) ? 1'b1 : 1'b0;
        von = (xx < 8) && (yy < 6);
        return {hs, vs, von, mb_ls, mb_fs, 10'(xx), 10'(yy)};
    endfunction

    // One clk: drive inputs, advance the model on the edge, settle past it.
    task automatic step(input logic r, input logic e);
        rst    = r;
        pix_en = e;
        @(posedge clk);
        if (r) begin
            ma_pos = 0; ma_ls = 1'b0; ma_fs = 1'b0;
            mb_pos = 0; mb_ls = 1'b0; mb_fs = 1'b0;
        end else if (e) begin
            ma_pos = (ma_pos + 1) % (A_HT * A_VT);
            ma_ls  = (ma_pos % A_HT) == 0;
            ma_fs  = ma_pos == 0;
            mb_pos = (mb_pos + 1) % (B_HT * B_VT);
            mb_ls  = (mb_pos % B_HT) == 0;
            mb_fs  = mb_pos == 0;
        end else begin
            ma_ls = 1'b0; ma_fs = 1'b0;
            mb_ls = 1'b0; mb_fs = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i[0]);
            vecs++;
            if (obs_a() !== exp_a()) begin
                errs++;
                $display("FAIL reset_a[%0d] got=%h exp=%h", i, obs_a(), exp_a());
            end
            vecs++;
            if (obs_b() !== exp_b()) begin
                errs++;
                $display("FAIL reset_b[%0d] got=%h exp=%h", i, obs_b(), exp_b());
            end
        end
        step(1'b0, 1'b0);
        vecs++;
        if ({a_line_start, a_frame_start, b_line_start, b_frame_start} !== 4'b0) begin
            errs++;
            $display("FAIL reset_release_strobes got=%b exp=0000",
                     {a_line_start, a_frame_start, b_line_start, b_frame_start});
        end
        step(1'b0, 1'b1);
        vecs++;
        if (a_x !== 10'd1 || a_y !== 10'd0) begin
            errs++;
            $display("FAIL reset_first_tick got x=%0d y=%0d exp x=1 y=0", a_x, a_y);
        end
    endtask

    task automatic test_line();
        int hs_low, ls_cnt;
        hs_low = 0;
        ls_cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            step(1'b0, (i % 4) == 3);
            vecs++;
            if (obs_a() !== exp_a()) begin
                errs++;
                $display("FAIL line_a[%0d] got=%h exp=%h", i, obs_a(), exp_a());
            end
            if ((i % 4) == 3 && a_hsync == 1'b0) hs_low++;
            if (a_line_start) begin
                ls_cnt++;
                vecs++;
                if (a_x !== 10'd0 || a_y !== 10'd1) begin
                    errs++;
                    $display("FAIL line_wrap_pos got x=%0d y=%0d exp x=0 y=1", a_x, a_y);
                end
            end
        end
        vecs++;
        if (hs_low != 96) begin
            errs++;
            $display("FAIL line_hsync_width got=%0d exp=96", hs_low);
        end
        vecs++;
        if (ls_cnt != 1) begin
            errs++;
            $display("FAIL line_start_count got=%0d exp=1", ls_cnt);
        end
    endtask

    task automatic test_hold();
        int n;
        n = 0;
        while ((ma_pos % A_HT) != 655 && n < 2000) begin
            step(1'b0, 1'b1);
            n++;
        end
        vecs++;
        if (a_x !== 10'd655) begin
            errs++;
            $display("FAIL hold_reach got x=%0d exp=655", a_x);
        end
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            vecs++;
            if (obs_a() !== exp_a()) begin
                errs++;
                $display("FAIL hold_frozen[%0d] got=%h exp=%h", i, obs_a(), exp_a());
            end
        end
        step(1'b0, 1'b1);
        vecs++;
        if (a_x !== 10'd656 || a_hsync !== 1'b0) begin
            errs++;
            $display("FAIL hold_resume got x=%0d hs=%b exp x=656 hs=0", a_x, a_hsync);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        n = 0;
        while ((ma_pos % A_HT) != 300 && n < 2000) begin
            step(1'b0, 1'b1);
            n++;
        end
        step(1'b1, 1'b1);
        vecs++;
        if (obs_a() !== exp_a() || a_x !== 10'd0 || a_frame_start !== 1'b0) begin
            errs++;
            $display("FAIL midreset_a got=%h exp=%h", obs_a(), exp_a());
        end
        n = 0;
        while (mb_pos != 69 && n < 500) begin
            step(1'b0, 1'b1);
            n++;
        end
        vecs++;
        if (b_x !== 5'd5 || b_y !== 5'd4) begin
            errs++;
            $display("FAIL midreset_b_reach got x=%0d y=%0d exp x=5 y=4", b_x, b_y);
        end
        step(1'b1, 1'b1);
        vecs++;
        if (obs_b() !== exp_b() || b_vsync !== 1'b0 || b_hsync !== 1'b0) begin
            errs++;
            $display("FAIL midreset_b got=%h exp=%h", obs_b(), exp_b());
        end
    endtask

    task automatic test_back_to_back();
        int fs_cnt, vs_cnt;
        fs_cnt = 0;
        vs_cnt = 0;
        for (int i = 0; i < 2 * B_HT * B_VT; i++) begin
            step(1'b0, 1'b1);
            vecs++;
            if (obs_b() !== exp_b()) begin
                errs++;
                $display("FAIL b2b_b[%0d] got=%h exp=%h", i, obs_b(), exp_b());
            end
            vecs++;
            if (obs_a() !== exp_a()) begin
                errs++;
                $display("FAIL b2b_a[%0d] got=%h exp=%h", i, obs_a(), exp_a());
            end
            if (b_frame_start) fs_cnt++;
            if (b_vsync) vs_cnt++;
        end
        vecs++;
        if (fs_cnt != 2) begin
            errs++;
            $display("FAIL b2b_frame_start_count got=%0d exp=2", fs_cnt);
        end
        vecs++;
        if (vs_cnt != 64) begin
            errs++;
            $display("FAIL b2b_vsync_clks got=%0d exp=64", vs_cnt);
        end
    endtask

    task automatic test_polarity();
        int hs_hi, ls_cnt;
        hs_hi  = 0;
        ls_cnt = 0;
        for (int i = 0; i < B_HT; i++) begin
            step(1'b0, 1'b1);
            if (b_hsync) begin
                hs_hi++;
                vecs++;
                if (b_x < 5'd10 || b_x > 5'd12) begin
                    errs++;
                    $display("FAIL pol_hsync_pos got x=%0d exp 10..12", b_x);
                end
            end
            if (b_line_start) ls_cnt++;
        end
        vecs++;
        if (hs_hi != 3) begin
            errs++;
            $display("FAIL pol_hsync_width got=%0d exp=3", hs_hi);
        end
        vecs++;
        if (ls_cnt != 1) begin
            errs++;
            $display("FAIL pol_line_period got=%0d exp=1", ls_cnt);
        end
    endtask

    task automatic test_random();
        logic r, e;
        for (int i = 0; i < 20000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            e = $urandom_range(0, 1) == 1;
            step(r, e);
            vecs++;
            if (obs_a() !== exp_a()) begin
                errs++;
                $display("FAIL rand_a[%0d] got=%h exp=%h", i, obs_a(), exp_a());
            end
            vecs++;
            if (obs_b() !== exp_b()) begin
                errs++;
                $display("FAIL rand_b[%0d] got=%h exp=%h", i, obs_b(), exp_b());
            end
        end
    endtask

    initial begin
        vecs   = 0;
        errs   = 0;
        rst    = 1'b1;
        pix_en = 1'b0;
        ma_pos = 0; ma_ls = 1'b0; ma_fs = 1'b0;
        mb_pos = 0; mb_ls = 1'b0; mb_fs = 1'b0;
        test_reset();
        test_line();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        test_polarity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
